montgomery_encode: RTL and testbench

- Converts a residue a (0 ≤ a < modulant) into the Montgomery domain: out = a·R mod modulant, where R = 2^bit_length.
- Inverse operation of mongomery_reduce, which leaves the domain. Sits in front of the Montgomery multiplier datapath.
- Iterative: one modular doubling per cycle, so no wide multiplier or divider is needed.
- Valid/ready handshake on both input and output.

---
 rtl/mont_pkg.sv | 16 +
 rtl/mont_double_mod.sv | 27 ++
 rtl/montgomery_encode.sv | 128 ++++++++++++
 tb/tb_montgomery_encode.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// Shared Montgomery-domain definitions: FSM states and default operand width.
// No logic; used by the encode, reduce and multiplier blocks.
// No backpressure; types and constants only.
package mont_pkg;

    // Default operand width for the Montgomery datapath.
    localparam int MONT_DATA_WIDTH = 8;

    // Iterative-operation control states shared by the Montgomery blocks.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mont_state_e;

endpackage : mont_pkg

// File: rtl/mont_double_mod.sv
// Modular doubling step: dbl_o = (2*acc_i) mod n_i, valid for acc_i < n_i.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module mont_double_mod #(
    parameter int W = 8
) (
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] n_i,
    output logic [W-1:0] dbl_o
);

    // 2*acc < 2n < 2^(W+1), so one extra bit holds the doubled value exactly.
    logic [W:0] dbl_w;
    logic [W:0] sub_w;

    assign dbl_w = {acc_i, 1'b0};
    assign sub_w = dbl_w - {1'b0, n_i};

    // One conditional subtract is enough to bring the result back below n.
    always_comb begin
        dbl_o = dbl_w[W-1:0];
        if (dbl_w >= {1'b0, n_i}) begin
            dbl_o = sub_w[W-1:0];
        end
    end

endmodule : mont_double_mod

// File: rtl/montgomery_encode.sv
// Montgomery encode: out = a * 2^L mod modulant, one modular doubling per cycle.
// Latency: L+1 cycles from accept to out_valid (1 cycle when L=0).
// Backpressure: valid/ready both sides; DONE holds out stable until out_ready.
// Optional MONT_ENCODE_CHECK_EN adds out_err and rejects bad operands at accept.
module montgomery_encode
    import mont_pkg::*;
#(
    parameter int DATA_WIDTH = MONT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] modulant,
    input  logic [DATA_WIDTH-1:0] bit_length,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out
`ifdef MONT_ENCODE_CHECK_EN
    ,
    output logic                  out_err
`endif
);

    localparam logic [DATA_WIDTH-1:0] LEN_MAX = DATA_WIDTH'(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] CNT_ONE = DATA_WIDTH'(1);

    mont_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] n_q, n_d;
    logic [DATA_WIDTH-1:0] len_clamped;
    logic [DATA_WIDTH-1:0] acc_dbl;
    logic                  accept;

`ifdef MONT_ENCODE_CHECK_EN
    logic err_q, err_d;
    logic bad_operands;

    // Reject a >= n, even n, and n < 3 before any work is done.
    assign bad_operands = (a >= modulant) || !modulant[0] || (modulant < DATA_WIDTH'(3));
    assign out_err      = err_q;
`endif

    assign len_clamped = (bit_length > LEN_MAX) ? LEN_MAX : bit_length;
    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign out         = acc_q;
    assign accept      = in_valid && in_ready;

    mont_double_mod #(
        .W (DATA_WIDTH)
    ) u_double (
        .acc_i (acc_q),
        .n_i   (n_q),
        .dbl_o (acc_dbl)
    );

    // Next-state logic: capture on accept, double while counting down, hold in DONE.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
`ifdef MONT_ENCODE_CHECK_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    n_d   = modulant;
                    acc_d = a;
                    cnt_d = len_clamped;
`ifdef MONT_ENCODE_CHECK_EN
                    err_d = 1'b0;
                    if (bad_operands) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else
`endif
                    begin
                        state_d = (len_clamped == '0) ? DONE : BUSY;
                    end
                end
            end
            BUSY: begin
                acc_d = acc_dbl;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            n_q     <= '0;
`ifdef MONT_ENCODE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
`ifdef MONT_ENCODE_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

endmodule : montgomery_encode

// File: tb/tb_montgomery_encode.sv
// Self-checking bench for montgomery_encode against a plain-arithmetic model.
// Drives one operation at a time; checks values, latency and handshake timing.
// Exercises backpressure and mid-operation reset.
module tb_montgomery_encode;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a;
    logic [DW-1:0] modulant;
    logic [DW-1:0] bit_length;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out;
`ifdef MONT_ENCODE_CHECK_EN
    logic          out_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    montgomery_encode #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .modulant   (modulant),
        .bit_length (bit_length),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out)
`ifdef MONT_ENCODE_CHECK_EN
        ,
        .out_err    (out_err)
`endif
    );

    always #5 clk = ~clk;

    // Reference: a * 2^L mod n with L clamped to DW.
    function automatic int ref_encode(input int av, input int nv, input int bl);
        longint p;
        int l;
        l = (bl > DW) ? DW : bl;
        p = longint'(av) << l;
        return int'(p % longint'(nv));
    endfunction

    function automatic int ref_latency(input int bl);
        int l;
        l = (bl > DW) ? DW : bl;
        return (l == 0) ? 1 : l + 1;
    endfunction

    // Reference Montgomery reduction t * 2^-L mod n (bitwise REDC, odd n, t < n).
    function automatic int ref_reduce(input int t, input int nv, input int l);
        longint x;
        x = t;
        for (int i = 0; i < l; i++) begin
            if (x[0]) x = x + nv;
            x = x >> 1;
        end
        if (x >= nv) x = x - nv;
        return int'(x);
    endfunction

    // Issue one operation, count cycles to out_valid, then complete the handshake.
    task automatic do_op(input int av, input int nv, input int bl,
                         output int res, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        in_valid   = 1'b1;
        a          = DW'(av);
        modulant   = DW'(nv);
        bit_length = DW'(bl);
        @(posedge clk); #1;
        in_valid   = 1'b0;
        a          = DW'($urandom);
        modulant   = DW'($urandom);
        bit_length = DW'($urandom);
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1; lat++;
        end
        res = int'(out);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; modulant = '0; bit_length = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== '0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b out=%0d, required 1 0 0",
                     in_ready, out_valid, out);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors;
        int vt_a[5]  = '{5, 0, 12, 250, 7};
        int vt_n[5]  = '{13, 13, 13, 251, 13};
        int vt_l[5]  = '{4, 4, 4, 8, 0};
        int vt_e[5]  = '{2, 0, 10, 246, 7};
        int vt_lt[5] = '{5, 5, 5, 9, 1};
        int res, lat;
        for (int i = 0; i < 5; i++) begin
            do_op(vt_a[i], vt_n[i], vt_l[i], res, lat);
            n_checks++;
            if (res !== vt_e[i]) begin
                n_fail++;
                $display("FAIL vector%0d_value: got %0d, required %0d", i, res, vt_e[i]);
            end
            n_checks++;
            if (lat !== vt_lt[i]) begin
                n_fail++;
                $display("FAIL vector%0d_latency: got %0d, required %0d", i, lat, vt_lt[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        int w;
        in_valid = 1'b1; a = 8'd5; modulant = 8'd13; bit_length = 8'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 64) begin
            @(posedge clk); #1; w++;
        end
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out !== 8'd2 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold%0d: out_valid=%b out=%0d in_ready=%b, required 1 2 0",
                         c, out_valid, out, in_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        n_checks++;
        if (out_valid !== 1'b1 || out !== 8'd2) begin
            n_fail++;
            $display("FAIL backpressure_handshake: out_valid=%b out=%0d, required 1 2", out_valid, out);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_release: in_ready=%b out_valid=%b, required 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_reset_busy;
        int res, lat;
        bit seen;
        in_valid = 1'b1; a = 8'd5; modulant = 8'd13; bit_length = 8'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy_idle: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        seen = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy_discard: stale out_valid seen=%b, required 0", seen);
        end
        do_op(12, 13, 4, res, lat);
        n_checks++;
        if (res !== 10) begin
            n_fail++;
            $display("FAIL reset_busy_recover: got %0d, required 10", res);
        end
    endtask

    task automatic test_random;
        int nv, av, bl, res, lat, exp_v;
        for (int i = 0; i < 40; i++) begin
            nv = ($urandom_range(1, 127) * 2) + 1;
            av = $urandom_range(0, nv - 1);
            bl = $urandom_range(0, 12);
            exp_v = ref_encode(av, nv, bl);
            do_op(av, nv, bl, res, lat);
            n_checks++;
            if (res !== exp_v || lat !== ref_latency(bl)) begin
                n_fail++;
                $display("FAIL random%0d: a=%0d n=%0d L=%0d got out=%0d lat=%0d, required %0d lat=%0d",
                         i, av, nv, bl, res, lat, exp_v, ref_latency(bl));
            end
        end
    endtask

    task automatic test_round_trip;
        int nv, av, res, lat, back;
        for (int i = 0; i < 20; i++) begin
            nv = ($urandom_range(1, 127) * 2) + 1;
            av = $urandom_range(0, nv - 1);
            do_op(av, nv, DW, res, lat);
            back = ref_reduce(res, nv, DW);
            n_checks++;
            if (back !== av) begin
                n_fail++;
                $display("FAIL round_trip%0d: n=%0d encoded=%0d reduced=%0d, required %0d",
                         i, nv, res, back, av);
            end
        end
    endtask

`ifdef MONT_ENCODE_CHECK_EN
    task automatic test_check;
        int res, lat;
        do_op(13, 13, 4, res, lat);
        n_checks++;
        if (res !== 0 || lat !== 1) begin
            n_fail++;
            $display("FAIL check_reject: out=%0d lat=%0d, required 0 1", res, lat);
        end
        in_valid = 1'b1; a = 8'd3; modulant = 8'd12; bit_length = 8'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_err !== 1'b1) begin
            n_fail++;
            $display("FAIL check_even_n: out_valid=%b out_err=%b, required 1 1", out_valid, out_err);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1; a = 8'd5; modulant = 8'd13; bit_length = 8'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_err !== 1'b0 || out !== 8'd2) begin
            n_fail++;
            $display("FAIL check_good: out_valid=%b out_err=%b out=%0d, required 1 0 2",
                     out_valid, out_err, out);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_busy();
        test_random();
        test_round_trip();
`ifdef MONT_ENCODE_CHECK_EN
        test_check();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_montgomery_encode
